fir_stream_param: RTL and testbench

- Parametrised, streaming direct-form FIR filter; successor to the fixed 32-tap FIR front end of the FAS datapath.
- Takes one signed fixed-point sample per `data_valid` cycle and emits one filtered sample per accepted input once the delay line is primed.
- Coefficients are run-time loadable through a write port instead of hard-coded.
- Output feeds the FFT stage and the standalone FIR checker.

---
 rtl/fir_stream_param.sv | 191 +++++++++++++++++++
 tb/tb_fir_stream_param.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_param.sv
// fir_stream_param
//   Streaming direct-form FIR filter with run-time loadable coefficients.
//   Each accepted sample shifts the delay line. Once TAPS samples have been
//   accepted since reset or flush, every accepted sample yields one rounded
//   result. That result appears on fir_d/fir_valid in the cycle after the
//   second clock edge following acceptance.
//
//   Optional build macro: FIR_SAT_EN
//     defined   - rounded result clamped to the OUT_W signed range, fir_sat flags clipping
//     undefined - low OUT_W bits of the rounded result (wrap), fir_sat constant 0
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset (clears coefficients too)
//   data_valid  sample strobe
//   data        signed input sample (DATA_W, DATA_FRAC fractional bits)
//   flush       synchronous clear of delay line, fill count and in-flight results
//   coef_we     coefficient write enable
//   coef_addr   coefficient index k
//   coef_wdata  signed coefficient value (COEF_W, COEF_FRAC fractional bits)
//   fir_valid   one-cycle pulse per result
//   fir_d       filtered sample (OUT_W, OUT_FRAC fractional bits), held between results
//   fir_sat     result was clipped (FIR_SAT_EN builds only)
module fir_stream_param #(
  parameter int TAPS      = 32,
  parameter int DATA_W    = 16,
  parameter int DATA_FRAC = 8,
  parameter int COEF_W    = 20,
  parameter int COEF_FRAC = 16,
  parameter int OUT_W     = 16,
  parameter int OUT_FRAC  = 8,
  localparam int ADDR_W   = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data,
  input  logic              flush,
  input  logic              coef_we,
  input  logic [ADDR_W-1:0] coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  output logic              fir_valid,
  output logic [OUT_W-1:0]  fir_d,
  output logic              fir_sat
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + ADDR_W;
  localparam int SHIFT  = DATA_FRAC + COEF_FRAC - OUT_FRAC;
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0]        FILL_INIT = CNT_W'(TAPS);
  localparam logic signed [ACC_W-1:0] HALF_LSB  = ACC_W'(1) << (SHIFT - 1);

  // ---------------------------------------------------------------------------
  // Coefficient register file
  // ---------------------------------------------------------------------------
  logic signed [COEF_W-1:0] coef [TAPS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) coef[k] <= '0;
    end else if (coef_we) begin
      for (int k = 0; k < TAPS; k++) begin
        if (coef_addr == ADDR_W'(k)) coef[k] <= coef_wdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Delay line and fill counter
  // ---------------------------------------------------------------------------
  // Only the TAPS-1 older samples are stored; the newest tap is the incoming
  // sample itself, so the products are formed on the accepting edge and see
  // the coefficient values from before any write on that same edge.
  logic signed [DATA_W-1:0] dly [TAPS-1];
  logic signed [DATA_W-1:0] win [TAPS];
  logic [CNT_W-1:0]         fill_rem;
  logic                     accept;
  logic                     prime_hit;

  assign accept    = data_valid & ~flush;
  // fill_rem counts down the samples still needed; 1 means this is the TAPS-th.
  assign prime_hit = (fill_rem <= CNT_W'(1));

  always_comb begin
    win[0] = data;
    for (int k = 1; k < TAPS; k++) win[k] = dly[k-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS-1; k++) dly[k] <= '0;
      fill_rem <= FILL_INIT;
    end else if (flush) begin
      for (int k = 0; k < TAPS-1; k++) dly[k] <= '0;
      fill_rem <= FILL_INIT;
    end else if (accept) begin
      for (int k = 0; k < TAPS-1; k++) dly[k] <= win[k];
      if (fill_rem != '0) fill_rem <= fill_rem - CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: tap products
  // ---------------------------------------------------------------------------
  logic signed [PROD_W-1:0] prod [TAPS];
  logic                     s1_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) prod[k] <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept & prime_hit;
      if (accept) begin
        for (int k = 0; k < TAPS; k++) begin
          prod[k] <= PROD_W'(win[k]) * PROD_W'(coef[k]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: full-precision accumulation
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] acc;
  logic                    s2_valid;

  always_comb begin
    sum = '0;
    for (int k = 0; k < TAPS; k++) sum = sum + ACC_W'(prod[k]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid & ~flush;
      if (s1_valid) acc <= sum;
    end
  end

  // ---------------------------------------------------------------------------
  // Round half up, reduce to OUT_W, output register
  // ---------------------------------------------------------------------------
  // The accumulator has headroom for the rounding bias, so the add cannot wrap.
  logic signed [ACC_W-1:0] acc_rnd;
  logic [OUT_W-1:0]        d_next;
  logic                    sat_next;

  assign acc_rnd = (acc + HALF_LSB) >>> SHIFT;

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] OUT_MAX = (ACC_W'(1) << (OUT_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  always_comb begin
    d_next   = OUT_W'(acc_rnd);
    sat_next = 1'b0;
    if (acc_rnd > OUT_MAX) begin
      d_next   = OUT_MAX[OUT_W-1:0];
      sat_next = 1'b1;
    end else if (acc_rnd < OUT_MIN) begin
      d_next   = OUT_MIN[OUT_W-1:0];
      sat_next = 1'b1;
    end
  end
`else
  assign d_next   = OUT_W'(acc_rnd);
  assign sat_next = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fir_valid <= 1'b0;
      fir_d     <= '0;
      fir_sat   <= 1'b0;
    end else if (flush) begin
      fir_valid <= 1'b0;
      fir_sat   <= 1'b0;
    end else begin
      fir_valid <= s2_valid;
      fir_sat   <= s2_valid & sat_next;
      if (s2_valid) fir_d <= d_next;
    end
  end

endmodule

// File: tb/tb_fir_stream_param.sv
module tb_fir_stream_param;

  localparam int TAPS = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_valid;
  logic [15:0] data;
  logic        flush;
  logic        coef_we;
  logic [4:0]  coef_addr;
  logic [19:0] coef_wdata;
  logic        fir_valid;
  logic [15:0] fir_d;
  logic        fir_sat;

  always #5 clk = ~clk;

  fir_stream_param dut (
    .clk        (clk),
    .rst        (rst),
    .data_valid (data_valid),
    .data       (data),
    .flush      (flush),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .fir_valid  (fir_valid),
    .fir_d      (fir_d),
    .fir_sat    (fir_sat)
  );

  typedef struct {
    int          due;
    logic [15:0] d;
    logic        s;
  } exp_t;

  exp_t        q[$];
  longint      mcoef [TAPS];
  longint      mdly  [TAPS];
  int          mfill;
  int          ecnt;
  logic [15:0] last_d;
  int          vectors;
  int          miscompares;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, ecnt);
    end
  endtask

  function automatic exp_t model_result(input int due);
    exp_t   e;
    longint acc;
    longint r;
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc += mcoef[k] * mdly[k];
    r = (acc + 64'sd32768) >>> 16;
    e.due = due;
`ifdef FIR_SAT_EN
    if (r > 32767) begin
      e.d = 16'h7FFF; e.s = 1'b1;
    end else if (r < -32768) begin
      e.d = 16'h8000; e.s = 1'b1;
    end else begin
      e.d = r[15:0]; e.s = 1'b0;
    end
`else
    e.d = r[15:0];
    e.s = 1'b0;
`endif
    return e;
  endfunction

  task automatic model_clear_all();
    q.delete();
    for (int k = 0; k < TAPS; k++) begin
      mcoef[k] = 0;
      mdly[k]  = 0;
    end
    mfill  = 0;
    last_d = '0;
  endtask

  task automatic check_outputs();
    if (q.size() > 0 && q[0].due == ecnt) begin
      exp_t e;
      e = q.pop_front();
      chk("valid", {31'b0, fir_valid}, 32'd1);
      chk("data",  {16'b0, fir_d},     {16'b0, e.d});
      chk("sat",   {31'b0, fir_sat},   {31'b0, e.s});
      last_d = e.d;
    end else begin
      chk("novalid", {31'b0, fir_valid}, 32'd0);
      chk("hold",    {16'b0, fir_d},     {16'b0, last_d});
      chk("nosat",   {31'b0, fir_sat},   32'd0);
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, check outputs.
  task automatic step(input logic dv, input logic [15:0] x, input logic fl,
                      input logic we, input logic [4:0] a, input logic [19:0] w);
    data_valid = dv;
    data       = x;
    flush      = fl;
    coef_we    = we;
    coef_addr  = a;
    coef_wdata = w;
    @(posedge clk);
    ecnt++;
    if (fl) begin
      for (int k = 0; k < TAPS; k++) mdly[k] = 0;
      mfill = 0;
      q.delete();
    end else if (dv) begin
      for (int k = TAPS-1; k > 0; k--) mdly[k] = mdly[k-1];
      mdly[0] = longint'($signed(x));
      if (mfill < TAPS) mfill++;
      if (mfill == TAPS) q.push_back(model_result(ecnt + 2));
    end
    if (we) mcoef[a] = longint'($signed(w));
    #1;
    check_outputs();
  endtask

  task automatic sample(input logic [15:0] x);
    step(1'b1, x, 1'b0, 1'b0, 5'd0, 20'd0);
  endtask

  task automatic idle();
    step(1'b0, 16'h0000, 1'b0, 1'b0, 5'd0, 20'd0);
  endtask

  task automatic wcoef(input logic [4:0] a, input logic [19:0] w);
    step(1'b0, 16'h0000, 1'b0, 1'b1, a, w);
  endtask

  task automatic do_flush(input logic dv, input logic [15:0] x);
    step(dv, x, 1'b1, 1'b0, 5'd0, 20'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    ecnt        = 0;
    model_clear_all();
    rst        = 1'b1;
    data_valid = 1'b0;
    data       = '0;
    flush      = 1'b0;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, fir_valid}, 32'd0);
    chk("rst_d",     {16'b0, fir_d},     32'd0);
    chk("rst_sat",   {31'b0, fir_sat},   32'd0);
    #3 rst = 1'b0;

    // Impulse / priming: 0x0100, 0x0080, then zeros
    wcoef(5'd0, 20'h10000);
    wcoef(5'd1, 20'h08000);
    for (int i = 0; i < 31; i++) sample(16'h0000);
    sample(16'h0100);
    chk("impulse_head", {16'b0, q[0].d}, 32'h0100);
    for (int i = 0; i < 4; i++) sample(16'h0000);
    repeat (3) idle();

    // DC gain with gaps in data_valid
    do_flush(1'b0, 16'h0000);
    for (int k = 0; k < TAPS; k++) wcoef(5'(k), 20'h00800);
    for (int i = 0; i < 80; i++) step((i % 2) == 0, 16'h0200, 1'b0, 1'b0, 5'd0, 20'd0);
    repeat (3) idle();
    chk("dc_last", {16'b0, last_d}, 32'h0200);

    // Rounding, plus a coefficient write on the same edge as a sample
    do_flush(1'b0, 16'h0000);
    wcoef(5'd0, 20'h08000);
    for (int k = 1; k < TAPS; k++) wcoef(5'(k), 20'h00000);
    for (int i = 0; i < 31; i++) sample(16'h0000);
    sample(16'h0001);
    sample(16'hFFFF);
    step(1'b1, 16'h0003, 1'b0, 1'b1, 5'd0, 20'h10000);
    sample(16'h0003);
    repeat (3) idle();
    chk("round_last", {16'b0, last_d}, 32'h0003);

    // Saturation / wrap
    do_flush(1'b0, 16'h0000);
    for (int k = 0; k < TAPS; k++) wcoef(5'(k), 20'h10000);
    for (int i = 0; i < 34; i++) sample(16'h7FFF);
    repeat (3) idle();
`ifdef FIR_SAT_EN
    chk("sat_value", {16'b0, last_d}, 32'h7FFF);
`else
    chk("wrap_value", {16'b0, last_d}, 32'hFFE0);
`endif

    // Flush mid-stream with results in flight; coefficients must survive
    for (int k = 0; k < TAPS; k++) begin
      wcoef(5'(k), ((k % 2) == 0) ? 20'(32'h00100 * (k + 1)) : 20'(-(32'h00080 * (k + 1))));
    end
    do_flush(1'b0, 16'h0000);
    for (int i = 0; i < 40; i++) sample(16'($urandom_range(0, 65535)));
    do_flush(1'b1, 16'h5A5A);
    for (int i = 0; i < 36; i++) sample(16'($urandom_range(0, 65535)));

    // Async reset between clock edges while streaming
    #2 rst = 1'b1;
    #1;
    model_clear_all();
    chk("arst_valid", {31'b0, fir_valid}, 32'd0);
    chk("arst_d",     {16'b0, fir_d},     32'd0);
    chk("arst_sat",   {31'b0, fir_sat},   32'd0);
    @(posedge clk);
    ecnt++;
    #1;
    check_outputs();
    #3 rst = 1'b0;
    for (int i = 0; i < 40; i++) sample(16'h1234);
    repeat (3) idle();
    chk("post_rst_zero", {16'b0, fir_d}, 32'h0000);
    chk("drained", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
